// File: rtl/token_word_packer.sv
// Packs a one-bit-per-cycle token stream into WIDTH-bit words tagged with length and
// popcount, and buffers them in a DEPTH-entry valid/ready FIFO.
module token_word_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int LW = $clog2(WIDTH + 1),
    localparam int FW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tok,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LW-1:0]    out_len,
    output logic [LW-1:0]    out_ones,
    output logic [FW-1:0]    fill,
    output logic             overflow
);

    logic [WIDTH-1:0] sreg;
    logic [LW-1:0]    k;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [LW-1:0]    mem_len  [DEPTH];
    logic [LW-1:0]    mem_ones [DEPTH];

    logic [WIDTH-1:0] bit_sel;
    logic [WIDTH-1:0] word_nxt;
    logic [LW-1:0]    cnt;
    logic [LW-1:0]    push_len;
    logic [LW-1:0]    push_ones;
    logic             push_full;
    logic             push_flush;
    logic             push;
    logic             pop;
    logic             push_acc;

    always_comb begin
        bit_sel    = WIDTH'(1) << k;
        word_nxt   = sreg | ((en && tok) ? bit_sel : '0);
        cnt        = k + LW'(en);
        push_full  = en && (k == LW'(WIDTH - 1));
        // A flush coinciding with a full word adds nothing: the full word already pushes.
        push_flush = flush && !push_full && (cnt != '0);
        push       = push_full || push_flush;
        push_len   = push_full ? LW'(WIDTH) : cnt;
        push_ones  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            push_ones = push_ones + LW'(word_nxt[i]);
        end
    end

    assign out_valid = (fill != '0);
    assign pop       = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push_acc  = push && ((fill != FW'(DEPTH)) || pop);

    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
    assign out_len   = out_valid ? mem_len[rd_ptr]  : '0;
    assign out_ones  = out_valid ? mem_ones[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg     <= '0;
            k        <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                sreg <= '0;
                k    <= '0;
            end else if (en) begin
                sreg <= word_nxt;
                k    <= cnt;
            end

            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (push_acc && !pop) begin
                fill <= fill + FW'(1);
            end else if (pop && !push_acc) begin
                fill <= fill - FW'(1);
            end

            if (push && !push_acc) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_acc) begin
            mem_data[wr_ptr] <= word_nxt;
            mem_len[wr_ptr]  <= push_len;
            mem_ones[wr_ptr] <= push_ones;
        end
    end

endmodule

// File: tb/tb_token_word_packer.sv
// Self-checking bench for token_word_packer: directed scenarios plus a randomized run
// against a queue-based model of the bit stream and word FIFO.
module tb_token_word_packer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(WIDTH + 1);
    localparam int FW = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             tok = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    out_len;
    logic [LW-1:0]    out_ones;
    logic [FW-1:0]    fill;
    logic             overflow;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int data;
        int len;
        int ones;
    } word_t;

    int    m_bits[$];
    word_t m_q[$];
    bit    m_ovf;

    token_word_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tok(tok), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_len(out_len), .out_ones(out_ones), .fill(fill), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model over the same edge, sample 1ns after.
    task automatic step(input bit e, input bit t, input bit f, input bit r);
        bit    do_pop;
        bit    do_push;
        word_t w;
        en = e; tok = t; flush = f; out_ready = r;
        @(posedge clk);
        if (!rst_n) begin
            m_bits.delete();
            m_q.delete();
            m_ovf = 0;
        end else begin
            do_pop = r && (m_q.size() > 0);
            if (e) m_bits.push_back(int'(t));
            do_push = (m_bits.size() == WIDTH) || (f && m_bits.size() > 0);
            if (do_push) begin
                w.data = 0; w.ones = 0; w.len = m_bits.size();
                foreach (m_bits[i]) begin
                    w.data += m_bits[i] * (1 << i);
                    w.ones += m_bits[i];
                end
                m_bits.delete();
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(w);
                else m_ovf = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] v, input bit last_ready);
        for (int i = 0; i < WIDTH; i++) step(1, v[i], 0, (i == WIDTH - 1) ? last_ready : 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || fill !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: valid=%0b fill=%0d ovf=%0b, want 0 0 0", out_valid, fill, overflow);
        end
        n_checks++;
        if (out_data !== '0 || out_len !== '0 || out_ones !== '0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h len=%0d ones=%0d, want 0", out_data, out_len, out_ones);
        end
    endtask

    task automatic test_full_word();
        logic [WIDTH-1:0] pat;
        pat = 8'h8D;
        for (int i = 0; i < WIDTH - 1; i++) step(1, pat[i], 0, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word_early: valid=%0b, want 0", out_valid);
        end
        step(1, pat[WIDTH-1], 0, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h8D || out_len !== LW'(8) || out_ones !== LW'(4)) begin
            n_fail++;
            $display("FAIL full_word: valid=%0b data=%h len=%0d ones=%0d, want 1 8d 8 4",
                     out_valid, out_data, out_len, out_ones);
        end
        step(0, 0, 0, 0);
        n_checks++;
        if (out_data !== 8'h8D || fill !== FW'(1)) begin
            n_fail++;
            $display("FAIL hold_head: data=%h fill=%0d, want 8d 1", out_data, fill);
        end
        step(0, 0, 0, 1);
        n_checks++;
        if (out_valid !== 1'b0 || fill !== '0) begin
            n_fail++;
            $display("FAIL pop_one: valid=%0b fill=%0d, want 0 0", out_valid, fill);
        end
    endtask

    task automatic test_flush();
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h03 || out_len !== LW'(3) || out_ones !== LW'(2)) begin
            n_fail++;
            $display("FAIL flush_partial: valid=%0b data=%h len=%0d ones=%0d, want 1 03 3 2",
                     out_valid, out_data, out_len, out_ones);
        end
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        n_checks++;
        if (out_valid !== 1'b0 || fill !== '0) begin
            n_fail++;
            $display("FAIL flush_empty: valid=%0b fill=%0d, want 0 0", out_valid, fill);
        end
        // flush together with the 8th bit yields exactly one full word
        for (int i = 0; i < WIDTH; i++) step(1, 1, (i == WIDTH - 1), 0);
        step(0, 0, 0, 0);
        n_checks++;
        if (fill !== FW'(1) || out_len !== LW'(8) || out_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL flush_with_full: fill=%0d len=%0d data=%h, want 1 8 ff", fill, out_len, out_data);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_alternate_en();
        for (int i = 0; i < 15; i++) step(i % 2 == 1, 1, 0, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alt_en_early: valid=%0b, want 0", out_valid);
        end
        step(1, 1, 0, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF || fill !== FW'(1)) begin
            n_fail++;
            $display("FAIL alt_en_word: valid=%0b data=%h fill=%0d, want 1 ff 1", out_valid, out_data, fill);
        end
        for (int i = 0; i < 16; i++) step(i % 2 == 1, 1, 0, 0);
        n_checks++;
        if (fill !== FW'(2)) begin
            n_fail++;
            $display("FAIL alt_en_second: fill=%0d, want 2", fill);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        for (int n = 1; n <= 5; n++) begin
            send_word(WIDTH'(n), 0);
            n_checks++;
            if (overflow !== (n == 5)) begin
                n_fail++;
                $display("FAIL ovf_flag_%0d: ovf=%0b, want %0b", n, overflow, n == 5);
            end
        end
        n_checks++;
        if (fill !== FW'(4)) begin
            n_fail++;
            $display("FAIL ovf_fill: fill=%0d, want 4", fill);
        end
        for (int n = 1; n <= 4; n++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== WIDTH'(n)) begin
                n_fail++;
                $display("FAIL drain_%0d: valid=%0b data=%h, want 1 %h", n, out_valid, out_data, n);
            end
            step(0, 0, 0, 1);
        end
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: valid=%0b ovf=%0b, want 0 1", out_valid, overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [WIDTH-1:0] v;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            v = WIDTH'($urandom);
            send_word(v, n == 4);
        end
        n_checks++;
        if (fill !== FW'(4) || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop: fill=%0d ovf=%0b, want 4 0", fill, overflow);
        end
        n_checks++;
        if (out_data !== WIDTH'(m_q[0].data)) begin
            n_fail++;
            $display("FAIL full_pop_head: data=%h, want %h", out_data, m_q[0].data);
        end
        for (int n = 0; n < 4; n++) step(0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] v;
        send_word(8'hA5, 0);
        send_word(8'h3C, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || fill !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%0b fill=%0d ovf=%0b, want 0 0 0", out_valid, fill, overflow);
        end
        v = WIDTH'($urandom);
        send_word(v, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== v || out_len !== LW'(8) || fill !== FW'(1)) begin
            n_fail++;
            $display("FAIL reset_fresh: valid=%0b data=%h len=%0d fill=%0d, want 1 %h 8 1",
                     out_valid, out_data, out_len, fill, v);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0);
            n_checks++;
            if (out_valid !== (m_q.size() > 0) || fill !== FW'(m_q.size()) || overflow !== m_ovf ||
                (m_q.size() > 0 && (out_data !== WIDTH'(m_q[0].data) || out_len !== LW'(m_q[0].len) ||
                                    out_ones !== LW'(m_q[0].ones)))) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_c%0d: v=%0b d=%h l=%0d o=%0d f=%0d ov=%0b, want f=%0d ov=%0b head=%h/%0d/%0d",
                             c, out_valid, out_data, out_len, out_ones, fill, overflow, m_q.size(), m_ovf,
                             (m_q.size() > 0) ? m_q[0].data : 0, (m_q.size() > 0) ? m_q[0].len : 0,
                             (m_q.size() > 0) ? m_q[0].ones : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_alternate_en();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
